instr_mem_ctrl: RTL and testbench

Parametrised next-generation instruction memory for the single-cycle/multicycle CPU datapath labs. Synchronous word-addressed fetch port with req/valid/stall handshake, a byte-enabled program-load write port, address fault detection, and a hardware clear engine that zeroes the array after reset or on request. Sits between PC logic and the instruction register/decoder.

---
 rtl/instr_mem_ctrl_pkg.sv | 16 +
 rtl/instr_mem_ctrl_if.sv | 31 +++
 rtl/instr_mem_ctrl_array.sv | 31 +++
 rtl/instr_mem_ctrl.sv | 162 ++++++++++++++++
 tb/tb_instr_mem_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_ctrl_pkg.sv
// Shared definitions for the instruction memory controller:
// FSM state encoding, fault bit positions and the default fault word.
package imem_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } imem_state_e;

  localparam int FAULT_MISALIGN = 0;
  localparam int FAULT_RANGE    = 1;

  // All-zero word is a MIPS nop, so a faulted fetch executes harmlessly.
  localparam logic [31:0] FAULT_WORD_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instr_mem_ctrl_if.sv
// Bus bundle between the PC/loader side (master) and the instruction memory (slave).
interface instr_mem_ctrl_if #(
  parameter int DATA_W = 32
);

  logic                  fetch_req;
  logic [31:0]           fetch_addr;
  logic                  fetch_stall;
  logic                  fetch_ready;
  logic                  fetch_valid;
  logic [DATA_W-1:0]     fetch_data;
  logic [1:0]            fetch_fault;
  logic                  wr_en;
  logic [31:0]           wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/8-1:0]   wr_be;
  logic                  wr_err;
  logic                  clear_req;
  logic                  busy;

  modport master (
    output fetch_req, fetch_addr, fetch_stall, wr_en, wr_addr, wr_data, wr_be, clear_req,
    input  fetch_ready, fetch_valid, fetch_data, fetch_fault, wr_err, busy
  );

  modport slave (
    input  fetch_req, fetch_addr, fetch_stall, wr_en, wr_addr, wr_data, wr_be, clear_req,
    output fetch_ready, fetch_valid, fetch_data, fetch_fault, wr_err, busy
  );

endinterface

// File: rtl/instr_mem_ctrl_array.sv
// Word storage: byte-enabled synchronous write, combinational read by index.
// Contents are intentionally not reset; the controller's clear engine zeroes them.
module imem_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem_r [2**ADDR_W];

  // Byte-lane write
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (wbe[i]) begin
          mem_r[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: clear engine FSM, fetch port with 1-cycle latency
// and stall hold, byte-enabled program-load port, and address fault detection.
module instr_mem_ctrl
  import imem_pkg::*;
#(
  parameter int               DATA_W         = 32,
  parameter int               ADDR_W         = 5,
  parameter bit               CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] FAULT_WORD    = DATA_W'(FAULT_WORD_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_mem_ctrl_if.slave   bus
);

  localparam int               NB        = DATA_W/8;
  localparam logic [ADDR_W-1:0] CNT_MAX  = '1;
  localparam imem_state_e      RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

  imem_state_e        state_r, state_nxt_s;
  logic [ADDR_W-1:0]  cnt_r, cnt_nxt_s;

  logic               fetch_valid_r;
  logic [DATA_W-1:0]  fetch_data_r;
  logic [1:0]         fetch_fault_r;
  logic               wr_err_r;

  logic [1:0]         f_fault_s, w_fault_s;
  logic [ADDR_W-1:0]  f_idx_s, w_idx_s;
  logic [DATA_W-1:0]  wmask_s;
  logic               busy_s, ready_s, w_legal_s, accept_s;
  logic               arr_we_s;
  logic [ADDR_W-1:0]  arr_waddr_s;
  logic [DATA_W-1:0]  arr_wdata_s, arr_rdata_s, rd_word_s;
  logic [NB-1:0]      arr_wbe_s;

  assign f_idx_s = bus.fetch_addr[ADDR_W+1:2];
  assign w_idx_s = bus.wr_addr[ADDR_W+1:2];

  // Address fault decode and byte-enable expansion
  always_comb begin
    f_fault_s                 = 2'b00;
    f_fault_s[FAULT_MISALIGN] = (bus.fetch_addr[1:0] != 2'b00);
    f_fault_s[FAULT_RANGE]    = |bus.fetch_addr[31:ADDR_W+2];
    w_fault_s                 = 2'b00;
    w_fault_s[FAULT_MISALIGN] = (bus.wr_addr[1:0] != 2'b00);
    w_fault_s[FAULT_RANGE]    = |bus.wr_addr[31:ADDR_W+2];
    wmask_s                   = '0;
    for (int i = 0; i < NB; i++) begin
      wmask_s[i*8 +: 8] = {8{bus.wr_be[i]}};
    end
  end

  // FSM next-state, clear engine write port and handshake qualifiers
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    busy_s      = 1'b0;
    ready_s     = 1'b0;
    w_legal_s   = 1'b0;
    arr_we_s    = 1'b0;
    arr_waddr_s = w_idx_s;
    arr_wdata_s = bus.wr_data;
    arr_wbe_s   = bus.wr_be;
    case (state_r)
      ST_CLEAR: begin
        busy_s      = 1'b1;
        arr_we_s    = 1'b1;
        arr_waddr_s = cnt_r;
        arr_wdata_s = '0;
        arr_wbe_s   = '1;
        if (cnt_r == CNT_MAX) begin
          state_nxt_s = ST_READY;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s = cnt_r + ADDR_W'(1);
        end
      end
      ST_READY: begin
        ready_s   = !(fetch_valid_r && bus.fetch_stall);
        w_legal_s = bus.wr_en && (w_fault_s == 2'b00);
        arr_we_s  = w_legal_s;
        if (bus.clear_req) begin
          state_nxt_s = ST_CLEAR;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_READY;
        end
      end
      default: begin
        state_nxt_s = RST_STATE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  assign accept_s = bus.fetch_req && ready_s;

  // Write-first forwarding when the fetch hits the word being written this edge
  always_comb begin
    if (w_legal_s && (w_idx_s == f_idx_s)) begin
      rd_word_s = (arr_rdata_s & ~wmask_s) | (bus.wr_data & wmask_s);
    end else begin
      rd_word_s = arr_rdata_s;
    end
  end

  imem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we_s),
    .waddr (arr_waddr_s),
    .wdata (arr_wdata_s),
    .wbe   (arr_wbe_s),
    .raddr (f_idx_s),
    .rdata (arr_rdata_s)
  );

  // FSM state and clear counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RST_STATE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Fetch result register with stall hold, plus write-drop pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid_r <= 1'b0;
      fetch_data_r  <= '0;
      fetch_fault_r <= 2'b00;
      wr_err_r      <= 1'b0;
    end else begin
      wr_err_r <= bus.wr_en && !w_legal_s;
      if (fetch_valid_r && bus.fetch_stall) begin
        fetch_valid_r <= fetch_valid_r;
        fetch_data_r  <= fetch_data_r;
        fetch_fault_r <= fetch_fault_r;
      end else if (accept_s) begin
        fetch_valid_r <= 1'b1;
        fetch_fault_r <= f_fault_s;
        fetch_data_r  <= (f_fault_s != 2'b00) ? FAULT_WORD : rd_word_s;
      end else begin
        fetch_valid_r <= 1'b0;
      end
    end
  end

  assign bus.fetch_ready = ready_s;
  assign bus.fetch_valid = fetch_valid_r;
  assign bus.fetch_data  = fetch_data_r;
  assign bus.fetch_fault = fetch_fault_r;
  assign bus.wr_err      = wr_err_r;
  assign bus.busy        = busy_s;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Scoreboard bench for instr_mem_ctrl: a word-array reference model predicts each
// fetch result into a queue; a negedge monitor pops and compares, and checks busy/ready/wr_err.
module tb_instr_mem_ctrl;

  localparam int DEPTH = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  instr_mem_ctrl_if #(.DATA_W(32)) bus ();

  instr_mem_ctrl #(
    .DATA_W         (32),
    .ADDR_W         (5),
    .CLEAR_ON_RESET (1'b1),
    .FAULT_WORD     (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  logic [31:0] mem [DEPTH];
  int          clear_left;
  logic        mvalid;
  logic [31:0] mdata;
  logic [1:0]  mfault;
  logic        m_wr_err;
  logic [33:0] exp_q [$];

  initial begin
    clear_left = DEPTH;
    mvalid     = 1'b0;
    mdata      = 32'h0;
    mfault     = 2'b00;
    m_wr_err   = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        clear_left = DEPTH;
        mvalid     = 1'b0;
        m_wr_err   = 1'b0;
        exp_q.delete();
      end else begin
        logic m_ready, w_ok, acc;
        int   widx, fidx;
        m_ready  = (clear_left == 0) && !(mvalid && bus.fetch_stall);
        w_ok     = bus.wr_en && (clear_left == 0) && (bus.wr_addr % 4 == 0) && (bus.wr_addr < DEPTH*4);
        m_wr_err = bus.wr_en && !w_ok;
        acc      = bus.fetch_req && m_ready;
        if (clear_left > 0) begin
          mem[DEPTH - clear_left] = 32'h0;
          clear_left--;
        end else begin
          if (w_ok) begin
            widx = int'(bus.wr_addr / 4);
            for (int b = 0; b < 4; b++)
              if (bus.wr_be[b]) mem[widx][b*8 +: 8] = bus.wr_data[b*8 +: 8];
          end
          if (bus.clear_req) clear_left = DEPTH;
        end
        if (mvalid && bus.fetch_stall) begin
          exp_q.push_back({mfault, mdata});
        end else if (acc) begin
          mfault[0] = (bus.fetch_addr % 4 != 0);
          mfault[1] = (bus.fetch_addr >= DEPTH*4);
          fidx      = int'((bus.fetch_addr / 4) % DEPTH);
          mdata     = (mfault != 2'b00) ? 32'h0 : mem[fidx];
          mvalid    = 1'b1;
          exp_q.push_back({mfault, mdata});
        end else begin
          mvalid = 1'b0;
        end
      end
    end
  end

  // Monitor: handshake outputs every cycle, fetch results against the queue
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        logic exp_ready;
        logic [33:0] e;
        exp_ready = (clear_left == 0) && !(mvalid && bus.fetch_stall);
        checks++;
        if (bus.busy !== (clear_left != 0)) begin
          errors++;
          $display("FAIL busy: got %b expected %b at %0t", bus.busy, clear_left != 0, $time);
        end
        checks++;
        if (bus.wr_err !== m_wr_err) begin
          errors++;
          $display("FAIL wr_err: got %b expected %b at %0t", bus.wr_err, m_wr_err, $time);
        end
        checks++;
        if (bus.fetch_ready !== exp_ready) begin
          errors++;
          $display("FAIL fetch_ready: got %b expected %b at %0t", bus.fetch_ready, exp_ready, $time);
        end
        if (bus.fetch_valid === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_valid: got valid=1 expected valid=0 at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            if (bus.fetch_data !== e[31:0] || bus.fetch_fault !== e[33:32]) begin
              errors++;
              $display("FAIL fetch: got data=%h fault=%b expected data=%h fault=%b at %0t",
                       bus.fetch_data, bus.fetch_fault, e[31:0], e[33:32], $time);
            end
          end
        end else if (exp_q.size() != 0) begin
          checks++;
          errors++;
          $display("FAIL missing_valid: got valid=%b expected valid=1 at %0t", bus.fetch_valid, $time);
          exp_q.delete();
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.fetch_req   = 1'b0;
    bus.fetch_stall = 1'b0;
    bus.wr_en       = 1'b0;
    bus.wr_be       = 4'h0;
    bus.clear_req   = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = a;
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.wr_be   = be;
  endtask

  task automatic count_busy(input string nm);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      cycle();
      n++;
    end
    chk(nm, 32'(n), 32'd32);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.fetch_addr = 32'h0;
    bus.wr_addr    = 32'h0;
    bus.wr_data    = 32'h0;
    idle();
    cycle();
    cycle();
    chk("rst_valid", 32'(bus.fetch_valid), 32'd0);
    chk("rst_data", bus.fetch_data, 32'h0);
    chk("rst_fault", 32'(bus.fetch_fault), 32'd0);
    chk("rst_wr_err", 32'(bus.wr_err), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_ready", 32'(bus.fetch_ready), 32'd0);
    rst_n = 1'b1;
    count_busy("busy_after_reset");

    fetch(32'h7C); cycle(); idle();
    chk("fetch_7c", bus.fetch_data, 32'h0);

    write(32'h10, 32'h8C01_0004, 4'hF); cycle(); idle();
    fetch(32'h10); cycle(); idle();
    chk("fetch_10", bus.fetch_data, 32'h8C01_0004);
    write(32'h10, 32'h0000_AA00, 4'b0010); cycle(); idle();
    fetch(32'h10); cycle(); idle();
    chk("fetch_10_merge", bus.fetch_data, 32'h8C01_AA04);

    write(32'h08, 32'h1111_1111, 4'hF); fetch(32'h08); cycle(); idle();
    chk("same_edge", bus.fetch_data, 32'h1111_1111);

    fetch(32'h06); cycle(); idle();
    chk("misalign_fault", 32'(bus.fetch_fault), 32'd1);
    fetch(32'h80); cycle(); idle();
    chk("range_fault", 32'(bus.fetch_fault), 32'd2);
    write(32'h80, 32'hFFFF_FFFF, 4'hF); cycle(); idle();
    chk("wr_err_range", 32'(bus.wr_err), 32'd1);
    cycle();
    chk("wr_err_pulse", 32'(bus.wr_err), 32'd0);

    write(32'h00, 32'hCAFE_0000, 4'hF); cycle(); idle();
    fetch(32'h00); cycle();
    fetch(32'h04); bus.fetch_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_ready", 32'(bus.fetch_ready), 32'd0);
      chk("stall_data", bus.fetch_data, 32'hCAFE_0000);
    end
    bus.fetch_stall = 1'b0;
    #1;
    chk("unstall_ready", 32'(bus.fetch_ready), 32'd1);
    cycle(); idle();
    chk("after_stall", bus.fetch_data, 32'h0);

    fetch(32'h10); cycle();
    fetch(32'h08); bus.clear_req = 1'b1; cycle(); idle();
    for (int i = 0; i < 9; i++) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    write(32'h0C, 32'h1234_5678, 4'hF);
    count_busy("busy_after_midclear_reset");
    idle();
    fetch(32'h10); cycle(); idle();
    chk("cleared_10", bus.fetch_data, 32'h0);

    for (int n = 0; n < 600; n++) begin
      logic [31:0] r;
      r = $urandom;
      bus.fetch_req   = r[0] | r[1];
      bus.fetch_stall = (r[4:2] == 3'd0);
      bus.wr_en       = (r[6:5] == 2'd0);
      bus.wr_be       = r[10:7];
      bus.clear_req   = (r[16:11] == 6'd0);
      bus.wr_data     = $urandom;
      case (r[19:17])
        3'd0:    bus.fetch_addr = $urandom;
        3'd1:    bus.fetch_addr = {25'h0, 5'($urandom), 2'($urandom_range(1, 3))};
        default: bus.fetch_addr = {25'h0, 5'($urandom), 2'b00};
      endcase
      case (r[22:20])
        3'd0:    bus.wr_addr = $urandom;
        3'd1:    bus.wr_addr = {25'h0, 5'($urandom), 2'($urandom_range(1, 3))};
        default: bus.wr_addr = {25'h0, 5'($urandom), 2'b00};
      endcase
      cycle();
    end
    idle();
    cycle();
    cycle();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
